// File: rtl/tcdm_stream_pkg.sv
// tcdm_stream_pkg: shared types for the TCDM stream reader.
// Address-width helper, FSM states and the request bundle.
package tcdm_stream_pkg;

  function automatic int unsigned tcdm_addr_width(
    input int unsigned nr_banks,
    input int unsigned depth,
    input int unsigned data_width
  );
    return $clog2(nr_banks * depth * data_width / 8);
  endfunction

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } state_e;

  // Width-independent request fields; a reader only ever issues
  // plain reads from the accelerator side.
  typedef struct packed {
    logic       write;
    logic [3:0] amo;
    logic [4:0] core_id;
    logic       is_core;
  } tcdm_req_t;

  localparam tcdm_req_t TcdmReadReq = '{
    write:   1'b0,
    amo:     4'h0,
    core_id: 5'h0,
    is_core: 1'b0
  };

endpackage

// File: rtl/tcdm_stream_fifo.sv
// tcdm_stream_fifo: response buffer for the stream reader.
// Power-of-two depth, push and pop allowed together when full.
module tcdm_stream_fifo
  import tcdm_stream_pkg::*;
#(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 64
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push,
  input  logic [Width-1:0]         wdata,
  input  logic                     pop,
  output logic [Width-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(Depth):0]   count
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  wr_ptr;
  logic [PtrW-1:0]  rd_ptr;
  logic [CntW-1:0]  cnt;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || pop);
  assign full    = (cnt == CntW'(Depth));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign rdata   = mem[rd_ptr];

  // Pointers wrap naturally because Depth is a power of two.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + CntW'(do_push) - CntW'(do_pop);
    end
  end

  // Storage needs no reset; only entries below count are visible.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/tcdm_stream_reader.sv
// tcdm_stream_reader: strided TCDM read requester with
// credit-based flow control and an in-order output stream.
module tcdm_stream_reader
  import tcdm_stream_pkg::*;
#(
  parameter int unsigned NarrowDataWidth = 64,
  parameter int unsigned TCDMDepth       = 64,
  parameter int unsigned NrBanks         = 8,
  parameter int unsigned TCDMAddrWidth   =
    tcdm_addr_width(NrBanks, TCDMDepth, NarrowDataWidth),
  parameter int unsigned FifoDepth       = 4,
  parameter int unsigned LenWidth        = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         start_i,
  input  logic [TCDMAddrWidth-1:0]     base_addr_i,
  input  logic [TCDMAddrWidth-1:0]     stride_i,
  input  logic [LenWidth-1:0]          len_i,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         err_o,
  output logic                         tcdm_req_write_o,
  output logic [TCDMAddrWidth-1:0]     tcdm_req_addr_o,
  output logic [3:0]                   tcdm_req_amo_o,
  output logic [NarrowDataWidth-1:0]   tcdm_req_data_o,
  output logic [4:0]                   tcdm_req_user_core_id_o,
  output logic                         tcdm_req_user_is_core_o,
  output logic [NarrowDataWidth/8-1:0] tcdm_req_strb_o,
  output logic                         tcdm_req_q_valid_o,
  input  logic                         tcdm_rsp_q_ready_i,
  input  logic                         tcdm_rsp_p_valid_i,
  input  logic [NarrowDataWidth-1:0]   tcdm_rsp_data_i,
  output logic [NarrowDataWidth-1:0]   data_o,
  output logic                         valid_o,
  input  logic                         ready_i
);

  localparam int unsigned CntW = $clog2(FifoDepth) + 1;
  localparam logic [CntW:0] CreditMax = (CntW + 1)'(FifoDepth);

  state_e                     state;
  logic [TCDMAddrWidth-1:0]   addr_q;
  logic [TCDMAddrWidth-1:0]   stride_q;
  logic [LenWidth-1:0]        len_q;
  logic [LenWidth-1:0]        issued_q;
  logic [LenWidth-1:0]        popped_q;
  logic [CntW-1:0]            outstanding_q;
  logic                       busy_q;
  logic                       done_q;
  logic                       err_q;

  logic [CntW-1:0]            fifo_count;
  logic                       fifo_full;
  logic                       fifo_empty;
  logic                       credit_ok;
  logic                       q_valid;
  logic                       req_hs;
  logic                       rsp_ok;
  logic                       rsp_stray;
  logic                       pop;
  logic                       last_issue;
  logic                       last_pop;

  // Every in-flight read owns a FIFO slot, so the buffer can never
  // overflow even though responses cannot be stalled. The sum only
  // grows on a handshake, hence q_valid never drops before ready.
  assign credit_ok =
    ({1'b0, outstanding_q} + {1'b0, fifo_count}) < CreditMax;

  assign q_valid    = (state == ISSUE) && credit_ok;
  assign req_hs     = q_valid && tcdm_rsp_q_ready_i;
  assign rsp_ok     = tcdm_rsp_p_valid_i && (outstanding_q != '0);
  assign rsp_stray  = tcdm_rsp_p_valid_i && (outstanding_q == '0);
  assign valid_o    = !fifo_empty;
  assign pop        = valid_o && ready_i;
  assign last_issue = req_hs && (issued_q == len_q - 1'b1);
  assign last_pop   = pop && (popped_q == len_q - 1'b1);

  assign busy_o                  = busy_q;
  assign done_o                  = done_q;
  assign err_o                   = err_q;
  assign tcdm_req_q_valid_o      = q_valid;
  assign tcdm_req_addr_o         = addr_q;
  assign tcdm_req_write_o        = TcdmReadReq.write;
  assign tcdm_req_amo_o          = TcdmReadReq.amo;
  assign tcdm_req_user_core_id_o = TcdmReadReq.core_id;
  assign tcdm_req_user_is_core_o = TcdmReadReq.is_core;
  assign tcdm_req_data_o         = '0;
  assign tcdm_req_strb_o         = '1;

  tcdm_stream_fifo #(
    .Depth (FifoDepth),
    .Width (NarrowDataWidth)
  ) i_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push   (rsp_ok),
    .wdata  (tcdm_rsp_data_i),
    .pop    (pop),
    .rdata  (data_o),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  // Reads in flight: up on a request, down on a matched response.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      outstanding_q <= '0;
    end else begin
      unique case ({req_hs, rsp_ok})
        2'b10:   outstanding_q <= outstanding_q + 1'b1;
        2'b01:   outstanding_q <= outstanding_q - 1'b1;
        default: outstanding_q <= outstanding_q;
      endcase
    end
  end

  // Transfer sequencing: launch, issue strided reads, drain output.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= IDLE;
      addr_q   <= '0;
      stride_q <= '0;
      len_q    <= '0;
      issued_q <= '0;
      popped_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start_i) begin
            err_q    <= 1'b0;
            addr_q   <= base_addr_i;
            stride_q <= stride_i;
            len_q    <= len_i;
            issued_q <= '0;
            popped_q <= '0;
            if (len_i != '0) begin
              state  <= ISSUE;
              busy_q <= 1'b1;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (pop) popped_q <= popped_q + 1'b1;
          if (req_hs) begin
            addr_q   <= addr_q + stride_q;
            issued_q <= issued_q + 1'b1;
            if (last_issue) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop) popped_q <= popped_q + 1'b1;
          if (last_pop) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
      if (rsp_stray) err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_tcdm_stream_reader.sv
// tb_tcdm_stream_reader: randomized bench with a TCDM responder
// and an address/data reference model for the stream reader.
module tb_tcdm_stream_reader;

  localparam int DW = 64;
  localparam int AW = 12;
  localparam int LW = 16;
  localparam int FD = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start;
  logic [AW-1:0] base;
  logic [AW-1:0] stride;
  logic [LW-1:0] len;
  logic          busy, done, err;
  logic          req_write;
  logic [AW-1:0] req_addr;
  logic [3:0]    req_amo;
  logic [DW-1:0] req_data;
  logic [4:0]    core_id;
  logic          is_core;
  logic [7:0]    strb;
  logic          q_valid, q_ready;
  logic          p_valid;
  logic [DW-1:0] rsp_data;
  logic [DW-1:0] data;
  logic          valid, ready;

  always #5 clk = ~clk;

  tcdm_stream_reader #(
    .NarrowDataWidth (DW),
    .TCDMDepth       (64),
    .NrBanks         (8),
    .TCDMAddrWidth   (AW),
    .FifoDepth       (FD),
    .LenWidth        (LW)
  ) dut (
    .clk_i                   (clk),
    .rst_ni                  (rst_n),
    .start_i                 (start),
    .base_addr_i             (base),
    .stride_i                (stride),
    .len_i                   (len),
    .busy_o                  (busy),
    .done_o                  (done),
    .err_o                   (err),
    .tcdm_req_write_o        (req_write),
    .tcdm_req_addr_o         (req_addr),
    .tcdm_req_amo_o          (req_amo),
    .tcdm_req_data_o         (req_data),
    .tcdm_req_user_core_id_o (core_id),
    .tcdm_req_user_is_core_o (is_core),
    .tcdm_req_strb_o         (strb),
    .tcdm_req_q_valid_o      (q_valid),
    .tcdm_rsp_q_ready_i      (q_ready),
    .tcdm_rsp_p_valid_i      (p_valid),
    .tcdm_rsp_data_i         (rsp_data),
    .data_o                  (data),
    .valid_o                 (valid),
    .ready_i                 (ready)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [AW-1:0] a;
    int            due;
  } rsp_t;

  logic [AW-1:0] exp_addr[$];
  rsp_t          rq[$];
  int            exp_len = 0;
  int            hs_idx = 0, pop_idx = 0, done_cnt = 0;
  int            stall_cyc = 0, hs_first = 0, hs_last = 0;
  logic [AW-1:0] hs_last_addr;
  logic [31:0]   salt = 32'h1234_5678;
  int            cyc = 0;
  int            ready_pct = 100, qready_pct = 100, rsp_pct = 100;
  int            lat_lo = 1, lat_hi = 1;
  int            stall_at = -1, stall_left = 0;
  bit            stray = 1'b0;
  logic          prev_pend = 1'b0;
  logic [AW-1:0] prev_addr;

  function automatic logic [63:0] word_of(input logic [AW-1:0] a);
    return {salt ^ {20'h0, a}, 32'(a) * 32'h9E37_79B1};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: everything sampled at negedge is what the next edge sees.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_pend = 1'b0;
    end else begin
      if (prev_pend) begin
        chk("qvalid_hold", 64'(q_valid), 64'd1);
        chk("addr_hold", 64'(req_addr), 64'(prev_addr));
      end
      if (q_valid && !q_ready) stall_cyc++;
      if (q_valid && q_ready) begin
        if (hs_idx < exp_len)
          chk("req_addr", 64'(req_addr), 64'(exp_addr[hs_idx]));
        else
          chk("extra_req", 64'(hs_idx), 64'(exp_len));
        rq.push_back('{req_addr, cyc + $urandom_range(lat_lo, lat_hi)});
        if (hs_idx == 0) hs_first = cyc;
        hs_last = cyc;
        hs_last_addr = req_addr;
        hs_idx++;
        chk("credit", 64'((hs_idx - pop_idx) <= FD), 64'd1);
      end
      prev_pend = q_valid && !q_ready;
      prev_addr = req_addr;
      if (valid && ready) begin
        if (pop_idx < exp_len)
          chk("data", data, word_of(exp_addr[pop_idx]));
        else
          chk("extra_pop", 64'(pop_idx), 64'(exp_len));
        pop_idx++;
      end
      if (done) begin
        done_cnt++;
        chk("done_after_last", 64'(pop_idx), 64'(exp_len));
        chk("busy_at_done", 64'(busy), 64'd0);
      end
    end
  end

  // Responder and downstream: in-order replies, latency >= 1.
  initial begin
    q_ready = 1'b0;
    p_valid = 1'b0;
    rsp_data = '0;
    ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      ready = ($urandom_range(0, 99) < ready_pct);
      if (q_valid && stall_at == hs_idx && stall_left > 0) begin
        q_ready = 1'b0;
        stall_left--;
      end else begin
        q_ready = ($urandom_range(0, 99) < qready_pct);
      end
      p_valid = 1'b0;
      if (stray) begin
        p_valid = 1'b1;
        rsp_data = '1;
        stray = 1'b0;
      end else if (rq.size() > 0 && rq[0].due <= cyc &&
                   $urandom_range(0, 99) < rsp_pct) begin
        p_valid = 1'b1;
        rsp_data = word_of(rq[0].a);
        void'(rq.pop_front());
      end
    end
  end

  task automatic check_reset(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_err"}, 64'(err), 64'd0);
    chk({tag, "_qvalid"}, 64'(q_valid), 64'd0);
    chk({tag, "_valid"}, 64'(valid), 64'd0);
    chk({tag, "_addr"}, 64'(req_addr), 64'd0);
  endtask

  task automatic launch(input int b, input int s, input int l);
    exp_addr.delete();
    for (int k = 0; k < l; k++)
      exp_addr.push_back(AW'((b + k * s) % (1 << AW)));
    exp_len = l;
    hs_idx = 0;
    pop_idx = 0;
    done_cnt = 0;
    stall_cyc = 0;
    salt = $urandom;
    @(posedge clk);
    #1;
    start = 1'b1;
    base = AW'(b);
    stride = AW'(s);
    len = LW'(l);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int t;
    t = 0;
    while (done_cnt == 0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_finished"}, 64'(done_cnt > 0), 64'd1);
    repeat (3) @(negedge clk);
    chk({tag, "_done_once"}, 64'(done_cnt), 64'd1);
    chk({tag, "_issued"}, 64'(hs_idx), 64'(exp_len));
    chk({tag, "_popped"}, 64'(pop_idx), 64'(exp_len));
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_err"}, 64'(err), 64'd0);
  endtask

  task automatic wait_rq_empty();
    int t;
    t = 0;
    while (rq.size() > 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("rsp_drain", 64'(rq.size()), 64'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    start = 1'b0;
    base = '0;
    stride = '0;
    len = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset("rst");
    chk("write", 64'(req_write), 64'd0);
    chk("amo", 64'(req_amo), 64'd0);
    chk("wdata", req_data, 64'd0);
    chk("core_id", 64'(core_id), 64'd0);
    chk("is_core", 64'(is_core), 64'd0);
    chk("strb", 64'(strb), 64'hFF);
    rst_n = 1'b1;

    launch(12'h010, 8, 4);
    wait_done("basic");
    chk("basic_b2b", 64'(hs_last - hs_first), 64'd3);
    chk("basic_last_addr", 64'(hs_last_addr), 64'h028);

    ready_pct = 0;
    launch(0, 8, 8);
    repeat (20) @(negedge clk);
    chk("credit_issued", 64'(hs_idx), 64'd4);
    chk("credit_qvalid", 64'(q_valid), 64'd0);
    chk("credit_valid", 64'(valid), 64'd1);
    ready_pct = 100;
    wait_done("credit");

    stall_at = 1;
    stall_left = 3;
    launch(12'h010, 8, 4);
    wait_done("bp");
    chk("bp_stall_cycles", 64'(stall_cyc), 64'd3);
    stall_at = -1;

    launch(12'hFF8, 16, 2);
    wait_done("wrap");
    chk("wrap_addr", 64'(hs_last_addr), 64'h008);

    exp_len = 0;
    pop_idx = 0;
    hs_idx = 0;
    done_cnt = 0;
    @(posedge clk);
    #1;
    start = 1'b1;
    len = '0;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    chk("zero_done", 64'(done), 64'd1);
    chk("zero_busy", 64'(busy), 64'd0);
    chk("zero_qvalid", 64'(q_valid), 64'd0);
    @(negedge clk);
    chk("zero_done_pulse", 64'(done), 64'd0);
    chk("zero_done_cnt", 64'(done_cnt), 64'd1);

    stray = 1'b1;
    repeat (3) @(negedge clk);
    chk("stray_err", 64'(err), 64'd1);
    chk("stray_valid", 64'(valid), 64'd0);
    chk("stray_busy", 64'(busy), 64'd0);

    lat_lo = 6;
    lat_hi = 6;
    launch(12'h100, 4, 6);
    @(negedge clk);
    chk("start_clears_err", 64'(err), 64'd0);
    begin
      int t;
      t = 0;
      while (hs_idx < 2 && t < 100) begin
        @(negedge clk);
        t++;
      end
      chk("mid_reach", 64'(hs_idx), 64'd2);
    end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("async_rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_len = 0;
    wait_rq_empty();
    chk("late_rsp_err", 64'(err), 64'd1);
    chk("late_rsp_valid", 64'(valid), 64'd0);
    chk("late_rsp_busy", 64'(busy), 64'd0);
    lat_lo = 1;
    lat_hi = 1;

    launch(12'h040, 8, 3);
    wait_done("fresh");

    for (int i = 0; i < 10; i++) begin
      ready_pct = $urandom_range(20, 100);
      qready_pct = $urandom_range(30, 100);
      rsp_pct = $urandom_range(50, 100);
      lat_lo = 1;
      lat_hi = $urandom_range(1, 4);
      launch($urandom_range(0, (1 << AW) - 1),
             $urandom_range(0, 64), $urandom_range(1, 24));
      wait_done("rand");
      wait_rq_empty();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
